// File: rtl/trivium_xor_cipher.sv
// trivium_xor_cipher: sequences a Trivium keystream generator through load and
// warm-up, gathers its serial keystream LSB-first into DATA_WIDTH-bit words and
// XORs each word with exactly one input data word under valid/ready handshakes.
module trivium_xor_cipher #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic                  trv_load,
   output logic                  trv_en,
   input  logic                  trv_warm_up_complete,
   input  logic                  trv_key_stream,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  din_valid,
   output logic                  din_ready,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_valid,
   input  logic                  dout_ready,
   output logic                  busy
);

   localparam int CNT_W = $clog2(DATA_WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_WARMUP  = 3'd2,
      S_GATHER  = 3'd3,
      S_HAVE_KS = 3'd4
   } state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]   ks_q, ks_d;
   logic [DATA_WIDTH-1:0]   dout_q, dout_d;
   logic                    dout_valid_q, dout_valid_d;
   logic                    din_hs;

   // State register; reset returns to IDLE without touching the generator.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; start wins from every state and restarts the session.
   always_comb begin
      state_d = state_q;
      if (start) begin
         state_d = S_LOAD;
      end else begin
         case (state_q)
            S_IDLE:    state_d = S_IDLE;
            S_LOAD:    state_d = S_WARMUP;
            S_WARMUP:  if (trv_warm_up_complete) state_d = S_GATHER;
            S_GATHER:  if (cnt_q == LAST_BIT) state_d = S_HAVE_KS;
            S_HAVE_KS: if (din_hs) state_d = S_GATHER;
            default:   state_d = S_IDLE;
         endcase
      end
   end

   // Moore-style controls plus the din handshake; no din is taken while start is high.
   always_comb begin
      trv_load  = (state_q == S_LOAD);
      trv_en    = (state_q == S_GATHER);
      busy      = (state_q != S_IDLE);
      din_ready = (state_q == S_HAVE_KS) && !start && (!dout_valid_q || dout_ready);
      din_hs    = din_ready && din_valid;
   end

   // Bit counter: cleared explicitly on entry to gathering, never wraps by overflow.
   always_comb begin
      cnt_d = cnt_q;
      if (start) begin
         cnt_d = '0;
      end else if (state_q == S_GATHER) begin
         cnt_d = (cnt_q == LAST_BIT) ? '0 : cnt_q + CNT_W'(1);
      end else if (state_q == S_WARMUP && trv_warm_up_complete) begin
         cnt_d = '0;
      end
   end

   // Each keystream bit lands in the position selected by the bit counter;
   // a restart throws away whatever part of the word was already gathered.
   for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_ks_bit
      assign ks_d[gi] = start ? 1'b0 :
                        ((state_q == S_GATHER) && (cnt_q == CNT_W'(gi))) ? trv_key_stream :
                        ks_q[gi];
   end

   // Output word register: holds until accepted, reloads on a din handshake.
   always_comb begin
      dout_d       = dout_q;
      dout_valid_d = dout_valid_q;
      if (dout_valid_q && dout_ready) begin
         dout_valid_d = 1'b0;
      end
      if (din_hs) begin
         dout_d       = din ^ ks_q;
         dout_valid_d = 1'b1;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         ks_q         <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         ks_q         <= ks_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_trivium_xor_cipher.sv
// tb_trivium_xor_cipher: directed bench using a programmable stub generator for
// sequencing/bit-order/backpressure/restart checks and a behavioural Trivium
// generator (key=0, IV=0) for the encrypt/decrypt round trip.
module tb_trivium_xor_cipher;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       trv_load, trv_en;
   logic       trv_warm_up_complete, trv_key_stream;
   logic [7:0] din;
   logic       din_valid, din_ready;
   logic [7:0] dout;
   logic       dout_valid, dout_ready;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   trivium_xor_cipher #(.DATA_WIDTH(8)) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .start                (start),
      .trv_load             (trv_load),
      .trv_en               (trv_en),
      .trv_warm_up_complete (trv_warm_up_complete),
      .trv_key_stream       (trv_key_stream),
      .din                  (din),
      .din_valid            (din_valid),
      .din_ready            (din_ready),
      .dout                 (dout),
      .dout_valid           (dout_valid),
      .dout_ready           (dout_ready),
      .busy                 (busy)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   // ---------------- stub generator ----------------
   logic       use_real = 1'b0;
   logic [7:0] stub_pat = 8'h00;
   logic [2:0] stub_idx = 3'd0;
   logic [3:0] stub_cnt = 4'd0;

   always @(posedge clk) begin
      if (trv_load) begin
         stub_cnt <= 4'd0;
         stub_idx <= 3'd0;
      end else begin
         if (stub_cnt != 4'hF) stub_cnt <= stub_cnt + 4'd1;
         if (trv_en) stub_idx <= stub_idx + 3'd1;
      end
   end

   // ---------------- behavioural Trivium ----------------
   function automatic logic [287:0] trv_init();
      logic [287:0] v;
      v = '0;
      v[285] = 1'b1;
      v[286] = 1'b1;
      v[287] = 1'b1;
      return v;
   endfunction

   function automatic logic trv_z(input logic [287:0] s);
      return s[65] ^ s[92] ^ s[161] ^ s[176] ^ s[242] ^ s[287];
   endfunction

   function automatic logic [287:0] trv_step(input logic [287:0] s);
      logic t1, t2, t3;
      logic [287:0] n;
      t1 = s[65]  ^ s[92]  ^ (s[90]  & s[91])  ^ s[170];
      t2 = s[161] ^ s[176] ^ (s[174] & s[175]) ^ s[263];
      t3 = s[242] ^ s[287] ^ (s[285] & s[286]) ^ s[68];
      n = s << 1;
      n[0]   = t3;
      n[93]  = t1;
      n[177] = t2;
      return n;
   endfunction

   logic [287:0] gen_s   = '0;
   int           gen_cnt = 0;

   always @(posedge clk) begin
      if (trv_load) begin
         gen_s   <= trv_init();
         gen_cnt <= 0;
      end else if (gen_cnt < 1152) begin
         gen_s   <= trv_step(gen_s);
         gen_cnt <= gen_cnt + 1;
      end else if (trv_en) begin
         gen_s <= trv_step(gen_s);
      end
   end

   assign trv_warm_up_complete = use_real ? (gen_cnt == 1152) : (stub_cnt >= 4'd5);
   assign trv_key_stream       = use_real ? trv_z(gen_s) : stub_pat[stub_idx];

   // ---------------- helpers ----------------
   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Offer one word and wait (bounded) for the handshake edge.
   task automatic send(input logic [7:0] data, input int budget);
      bit got;
      got = 1'b0;
      din = data;
      din_valid = 1'b1;
      for (int n = 0; n < budget; n++) begin
         @(negedge clk);
         if (din_ready) begin
            got = 1'b1;
            break;
         end
      end
      check("din_ready_wait", din_ready, 1'b1);
      @(posedge clk); #1;
      din_valid = 1'b0;
   endtask

   logic [7:0] ref_ks [16];
   logic [7:0] pt [16];
   logic [7:0] ct [16];

   int load_first, load_cnt, en_first, en_last, en_cnt, rdy_first;

   initial begin
      logic [287:0] s;
      rst_n = 1'b0; start = 1'b0; din = 8'h00; din_valid = 1'b1; dout_ready = 1'b1;

      // reference keystream for key=0, IV=0, LSB-first bytes
      s = trv_init();
      repeat (1152) s = trv_step(s);
      for (int w = 0; w < 16; w++) begin
         for (int b = 0; b < 8; b++) begin
            ref_ks[w][b] = trv_z(s);
            s = trv_step(s);
         end
         pt[w] = 8'(w * 17 + 3);
      end

      // 1. reset
      repeat (3) @(negedge clk);
      check("rst_din_ready", din_ready, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_trv_load", trv_load, 1'b0);
      check("rst_trv_en", trv_en, 1'b0);
      check("rst_dout_valid", dout_valid, 1'b0);
      check("rst_dout", dout, 8'h00);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_busy", busy, 1'b0);
      check("idle_din_ready", din_ready, 1'b0);
      din_valid = 1'b0;

      // 2. sequencing with the stub; pattern 1,0,1,1,0,0,0,0 -> 0x0D
      @(posedge clk); #1;
      stub_pat = 8'h0D;
      load_first = -1; load_cnt = 0; en_first = -1; en_last = -1; en_cnt = 0; rdy_first = -1;
      start = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (trv_load) begin
            load_cnt++;
            if (load_first < 0) load_first = i;
         end
         if (trv_en) begin
            en_cnt++;
            if (en_first < 0) en_first = i;
            en_last = i;
         end
         if (din_ready && rdy_first < 0) rdy_first = i;
         @(posedge clk); #1;
         start = 1'b0;
      end
      check("seq_load_pos", 64'(load_first), 64'd1);
      check("seq_load_cnt", 64'(load_cnt), 64'd1);
      check("seq_en_first", 64'(en_first), 64'd8);
      check("seq_en_cnt", 64'(en_cnt), 64'd8);
      check("seq_en_last", 64'(en_last), 64'd15);
      check("seq_rdy_first", 64'(rdy_first), 64'd16);

      // 3. bit order: 0xFF ^ 0x0D
      check("pre_dout_valid", dout_valid, 1'b0);
      send(8'hFF, 20);
      @(negedge clk);
      check("bitord_valid", dout_valid, 1'b1);
      check("bitord_dout", dout, 8'hF2);
      @(posedge clk); #1;

      // 4. backpressure across two words
      dout_ready = 1'b0;
      send(8'h00, 30);
      @(negedge clk);
      check("bp_first_dout", dout, 8'h0D);
      din = 8'h11;
      din_valid = 1'b1;
      repeat (20) @(negedge clk);
      check("bp_din_ready_low", din_ready, 1'b0);
      check("bp_dout_hold", dout, 8'h0D);
      check("bp_valid_hold", dout_valid, 1'b1);
      @(posedge clk); #1;
      dout_ready = 1'b1;
      send(8'h11, 3);
      @(negedge clk);
      check("bp_second_dout", dout, 8'h1C);
      check("bp_second_valid", dout_valid, 1'b1);

      // 5. restart at bit 3 of a gather; new session pattern 0xA5
      @(posedge clk); #1;
      stub_pat = 8'hA5;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (trv_en) break;
      end
      check("rs_in_gather", trv_en, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      pulse_start();
      @(negedge clk);
      check("rs_load_pulse", trv_load, 1'b1);
      send(8'h00, 40);
      @(negedge clk);
      check("rs_dout", dout, 8'hA5);
      @(posedge clk); #1;

      // 6. full Trivium: encrypt 16 bytes, then decrypt in a restarted session
      use_real = 1'b1;
      pulse_start();
      for (int w = 0; w < 16; w++) begin
         send(pt[w], 2000);
         @(negedge clk);
         ct[w] = dout;
         check($sformatf("enc%0d", w), dout, pt[w] ^ ref_ks[w]);
      end
      @(posedge clk); #1;
      pulse_start();
      for (int w = 0; w < 16; w++) begin
         send(ct[w], 2000);
         @(negedge clk);
         check($sformatf("dec%0d", w), dout, pt[w]);
      end

      // asynchronous reset mid-session with a pending output word
      @(posedge clk); #1;
      dout_ready = 1'b0;
      send(8'h3C, 30);
      @(negedge clk);
      check("pend_valid", dout_valid, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid", dout_valid, 1'b0);
      check("arst_dout", dout, 8'h00);
      check("arst_busy", busy, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/trivium_xor_cipher.md
Name: trivium_xor_cipher

Overview:
Downstream consumer of the Trivium keystream generator. It sequences the generator through load and warm-up, then gathers the serial key_stream bits into DATA_WIDTH-bit keystream words. Each word is XORed with one input data word under a valid/ready handshake, so the block sits between the generator and the byte/word-oriented datapath for encryption and decryption.

Parameters:
DATA_WIDTH, 8, width of the data and keystream words; legal range 1..64.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle request to begin a new session; generator loads the key/IV currently on its inputs.
trv_load  output  1  drives the generator's load/rst input.
trv_en  output  1  drives the generator's en input; advances the keystream by one bit per cycle.
trv_warm_up_complete  input  1  warm_up_complete from the generator.
trv_key_stream  input  1  key_stream from the generator; combinational from current generator state.
din  input  DATA_WIDTH  plaintext or ciphertext word.
din_valid  input  1  din is valid.
din_ready  output  1  block accepts din this cycle.
dout  output  DATA_WIDTH  din XOR keystream word.
dout_valid  output  1  dout is valid.
dout_ready  input  1  downstream accepts dout.
busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; all outputs 0 (trv_load, trv_en, din_ready, dout, dout_valid, busy).
  - ks_reg=0, bit counter=0.
- States:
  - IDLE: din_ready=0. start=1 -> LOAD.
  - LOAD: exactly one cycle with trv_load=1, trv_en=0. Always -> WARMUP.
  - WARMUP: trv_en=0 (the generator free-runs during warm-up). trv_warm_up_complete=1 -> GATHER, bit counter=0. Because LOAD precedes WARMUP by one cycle, a stale high from a previous session is never observed.
  - GATHER: trv_en=1 for exactly DATA_WIDTH consecutive cycles. On each rising edge, ks_reg[bit counter] <= trv_key_stream. The first generated bit goes to LSB. On the last bit -> HAVE_KS.
  - HAVE_KS: trv_en=0. din_ready = !dout_valid | dout_ready. On a din handshake: dout <= din ^ ks_reg, dout_valid <= 1, then -> GATHER with bit counter=0.
- Keystream use: each keystream word is used exactly once, never reused and never skipped.
- Output handshake:
  - dout_valid stays high and dout holds stable until dout_ready=1.
  - dout_valid clears on a dout handshake unless a new word is loaded in the same cycle. In that case dout updates and dout_valid stays 1.
- Latency and throughput:
  - din handshake -> dout_valid on the next cycle.
  - Steady-state throughput is one word per DATA_WIDTH+1 cycles.
  - From start to the first din_ready: 1 (LOAD) + warm-up wait + DATA_WIDTH cycles.
- start in any non-IDLE state:
  - Aborts the session: -> LOAD, and the partial or complete ks_reg is discarded.
  - A pending dout/dout_valid is kept until accepted.
  - A din handshake is not taken in a cycle where start=1.
- start in IDLE has the same effect as start in any other state.
- busy=1 in LOAD, WARMUP, GATHER and HAVE_KS.
- Bit counter width is clog2(DATA_WIDTH+1). It wraps only via an explicit clear, never by overflow.
- No IDLE return after the first start. A session continues until reset or the next start.
- rst_n asserted mid-operation: immediate return to the reset values above. The generator is not touched; the next start reloads it.

Test Plan:
1. Reset check: hold rst_n=0 for 3 cycles, then release -> all outputs 0, state IDLE, din_ready=0 even with din_valid=1.
2. Sequencing with a stub generator: pulse start; stub raises warm_up_complete 5 cycles after trv_load -> trv_load high exactly 1 cycle; trv_en low during WARMUP, then high for exactly 8 cycles; din_ready rises on the cycle after the 8th trv_en cycle.
3. Bit order: stub emits 1,0,1,1,0,0,0,0 on successive trv_en cycles; din=0xFF -> dout=0xF2 (ks=0x0D), dout_valid one cycle after the handshake.
4. Backpressure: hold dout_ready=0 across two words -> din_ready stays 0 after the first word; dout holds its first value; the second keystream word is gathered and held; releasing dout_ready accepts the second din in the same cycle.
5. Restart mid-GATHER: assert start at bit 3 -> trv_load pulses; the partial word is discarded; the next word uses only bits from the new session (stub pattern 0xA5 -> din 0x00 gives dout 0xA5).
6. Full generator integration, key=0, IV=0, DATA_WIDTH=8: encrypt 16 bytes and compare against the reference model; then feed the ciphertext through a second restarted session -> the original plaintext is recovered.
